// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Opcode and FSM state encodings shared by the sequential ALU,
//               plus the long-operation classifier.
// Revision    : 1.0
// ============================================================================
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0,
        OP_SUB  = 4'h1,
        OP_AND  = 4'h2,
        OP_OR   = 4'h3,
        OP_XOR  = 4'h4,
        OP_NOR  = 4'h5,
        OP_SLT  = 4'h6,
        OP_SLTU = 4'h7,
        OP_SLL  = 4'h8,
        OP_SRL  = 4'h9,
        OP_SRA  = 4'hA,
        OP_MUL  = 4'hB,
        OP_MULU = 4'hC,
        OP_DIV  = 4'hD,
        OP_DIVU = 4'hE,
        OP_RSVD = 4'hF
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Multiplies only iterate when no combinational multiplier is built.
    function automatic logic is_long_op(input alu_op_e op, input logic fast_mul);
        return (op == OP_DIV) || (op == OP_DIVU) ||
               (!fast_mul && ((op == OP_MUL) || (op == OP_MULU)));
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_muldiv_iter.sv
`default_nettype none
// ============================================================================
// Module      : alu_muldiv_iter
// Description : One-bit-per-cycle shift-add multiplier / restoring divider on
//               operand magnitudes, with sign fix-up on the outputs.
// Revision    : 1.0
// ============================================================================
module alu_muldiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_div,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             last,
    output logic             done,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi,
    output logic             dbz
);

    localparam int SHW = $clog2(WIDTH);
    localparam logic [SHW-1:0] c_last_cnt = SHW'(WIDTH - 1);

    logic             r_run;
    logic             r_fix;
    logic             r_div;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_dbz;
    logic [SHW-1:0]   r_cnt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_m;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [WIDTH:0]     w_msum;
    logic [WIDTH:0]     w_dshift;
    logic [WIDTH:0]     w_ddiff;
    logic               w_qbit;
    logic [2*WIDTH-1:0] w_prod_neg;

    assign w_mag_a = (is_signed && a[WIDTH-1]) ? (~a + 1'b1) : a;
    assign w_mag_b = (is_signed && b[WIDTH-1]) ? (~b + 1'b1) : b;

    // Multiply: {r_hi,r_lo} is the product shift register, r_lo[0] the current multiplier bit.
    assign w_msum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_m} : {(WIDTH+1){1'b0}});

    // Divide: r_hi is the partial remainder, dividend bits shift out of r_lo as quotient bits enter.
    assign w_dshift = {r_hi, r_lo[WIDTH-1]};
    assign w_ddiff  = w_dshift - {1'b0, r_m};
    assign w_qbit   = ~w_ddiff[WIDTH];

    assign w_prod_neg = ~{r_hi, r_lo} + 1'b1;

    assign last = r_run && (r_cnt == c_last_cnt);
    assign done = r_fix;
    assign dbz  = r_dbz;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run   <= 1'b0;
            r_fix   <= 1'b0;
            r_div   <= 1'b0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_dbz   <= 1'b0;
            r_cnt   <= '0;
            r_a     <= '0;
            r_m     <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else if (start) begin
            r_run   <= 1'b1;
            r_fix   <= 1'b0;
            r_div   <= is_div;
            r_neg_q <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
            r_neg_r <= is_signed && a[WIDTH-1];
            r_dbz   <= is_div && (b == '0);
            r_cnt   <= '0;
            r_a     <= a;
            r_m     <= w_mag_b;
            r_hi    <= '0;
            r_lo    <= w_mag_a;
        end else if (r_run) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_div) begin
                r_hi <= w_qbit ? w_ddiff[WIDTH-1:0] : w_dshift[WIDTH-1:0];
                r_lo <= {r_lo[WIDTH-2:0], w_qbit};
            end else begin
                r_hi <= w_msum[WIDTH:1];
                r_lo <= {w_msum[0], r_lo[WIDTH-1:1]};
            end
            if (last) begin
                r_run <= 1'b0;
                r_fix <= 1'b1;
            end
        end else begin
            r_fix <= 1'b0;
        end
    end

    // Quotient truncates toward zero; remainder follows the dividend's sign.
    always_comb begin
        lo = r_lo;
        hi = r_hi;
        if (r_div) begin
            if (r_dbz) begin
                lo = '1;
                hi = r_a;
            end else begin
                lo = r_neg_q ? (~r_lo + 1'b1) : r_lo;
                hi = r_neg_r ? (~r_hi + 1'b1) : r_hi;
            end
        end else if (r_neg_q) begin
            {hi, lo} = w_prod_neg;
        end
    end

endmodule
`default_nettype wire

// File: rtl/seq_alu.sv
`default_nettype none
// ============================================================================
// Module      : seq_alu
// Description : Execute-stage ALU with valid/ready handshakes; single-cycle
//               logic/arith/shift ops and iterative multiply/divide.
// Revision    : 1.0
// ============================================================================
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter bit FAST_MUL = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero,
    output logic             overflow,
    output logic             div_by_zero
);

    localparam int SHW = $clog2(WIDTH);

    state_e r_state;
    logic   r_live;

    alu_op_e            w_op;
    logic               w_long;
    logic               w_accept;
    logic [SHW-1:0]     w_sh;
    logic [WIDTH-1:0]   w_sum;
    logic [WIDTH-1:0]   w_dif;
    logic [2*WIDTH-1:0] w_prod_s;
    logic [2*WIDTH-1:0] w_prod_u;
    logic [WIDTH-1:0]   w_res;
    logic [WIDTH-1:0]   w_hi;
    logic               w_ovf;
    logic               w_zero_en;
    logic               w_md_last;
    logic               w_md_done;
    logic               w_md_dbz;
    logic [WIDTH-1:0]   w_md_lo;
    logic [WIDTH-1:0]   w_md_hi;

    assign w_op     = alu_op_e'(op);
    assign w_long   = is_long_op(w_op, FAST_MUL);
    // r_live holds off acceptance for the first cycle after reset release.
    assign in_ready = r_live && ((r_state == ST_IDLE) || ((r_state == ST_DONE) && out_ready));
    assign w_accept = in_valid && in_ready;
    assign w_sh     = b[SHW-1:0];
    assign w_sum    = a + b;
    assign w_dif    = a - b;

    generate
        if (FAST_MUL) begin : g_fast_mul
            assign w_prod_s = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
            assign w_prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
        end else begin : g_iter_mul
            assign w_prod_s = '0;
            assign w_prod_u = '0;
        end
    endgenerate

    always_comb begin
        w_res     = '0;
        w_hi      = '0;
        w_ovf     = 1'b0;
        w_zero_en = 1'b1;
        case (w_op)
            OP_ADD: begin
                w_res = w_sum;
                w_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                w_res = w_dif;
                w_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (w_dif[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  w_res = a & b;
            OP_OR:   w_res = a | b;
            OP_XOR:  w_res = a ^ b;
            OP_NOR:  w_res = ~(a | b);
            OP_SLT:  w_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: w_res = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_SLL:  w_res = a << w_sh;
            OP_SRL:  w_res = a >> w_sh;
            OP_SRA:  w_res = $signed(a) >>> w_sh;
            OP_MUL:  {w_hi, w_res} = w_prod_s;
            OP_MULU: {w_hi, w_res} = w_prod_u;
            default: w_zero_en = 1'b0;
        endcase
    end

    alu_muldiv_iter #(
        .WIDTH (WIDTH)
    ) u_muldiv (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (w_accept && w_long),
        .is_div    ((w_op == OP_DIV) || (w_op == OP_DIVU)),
        .is_signed ((w_op == OP_MUL) || (w_op == OP_DIV)),
        .a         (a),
        .b         (b),
        .last      (w_md_last),
        .done      (w_md_done),
        .lo        (w_md_lo),
        .hi        (w_md_hi),
        .dbz       (w_md_dbz)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_live      <= 1'b0;
            out_valid   <= 1'b0;
            result      <= '0;
            result_hi   <= '0;
            zero        <= 1'b0;
            overflow    <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            r_live <= 1'b1;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_accept) begin
                        if (w_long) begin
                            r_state   <= ST_ITER;
                            out_valid <= 1'b0;
                        end else begin
                            r_state     <= ST_DONE;
                            out_valid   <= 1'b1;
                            result      <= w_res;
                            result_hi   <= w_hi;
                            zero        <= w_zero_en && (w_res == '0);
                            overflow    <= w_ovf;
                            div_by_zero <= 1'b0;
                        end
                    end else if ((r_state == ST_DONE) && out_ready) begin
                        r_state   <= ST_IDLE;
                        out_valid <= 1'b0;
                    end
                end
                ST_ITER: begin
                    if (w_md_last) begin
                        r_state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    if (w_md_done) begin
                        r_state     <= ST_DONE;
                        out_valid   <= 1'b1;
                        result      <= w_md_lo;
                        result_hi   <= w_md_hi;
                        zero        <= (w_md_lo == '0);
                        overflow    <= 1'b0;
                        div_by_zero <= w_md_dbz;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
